metaball_scan: RTL
==================

Name: metaball_scan

Overview:
- Pixel-side driver of the metaball evaluation interface. Metaballs consume px_stb/p_x/p_y and return out/vld.
- Per frame, sweeps every pixel of an H_RES x V_RES grid and strobes all metaball instances with the pixel coordinate in Q16.15.
- Waits for the per-pixel handshake, sums the field contributions, thresholds the sum, and writes one bit per pixel to the framebuffer.
- Pulses mov_en once per completed frame so the balls advance.

Parameters:
- H_RES, 40, pixels per row.
- V_RES, 30, rows per frame.
- N_BALLS, 2, number of metaball instances driven in parallel.
- THRESH, 32'h0000_8000, Q16.15 iso-level (1.0). Pixel is set when sum >= THRESH.
- ACK_TO, 8, max cycles to wait for vld to drop after a strobe.
- AW, $clog2(H_RES*V_RES), framebuffer address width.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- frame_go  in  1  one-cycle request to render a frame
- px_stb  out  1  one-cycle strobe to all metaballs; p_x/p_y valid this cycle
- p_x  out  32  Q16.15 pixel x (col << 15)
- p_y  out  32  Q16.15 pixel y (row << 15)
- vld  in  N_BALLS  per-ball result valid; high when idle, low while dividing
- out  in  32*N_BALLS  per-ball Q16.15 field value; ball k at [32k+31:32k]
- wr_en  out  1  framebuffer write strobe
- wr_addr  out  AW  row*H_RES + col
- wr_data  out  1  pixel on/off
- mov_en  out  1  one-cycle pulse after last pixel write
- busy  out  1  high from frame_go accept until the mov_en cycle inclusive

Behaviour:
- Reset (rst=0, async) forces state IDLE, col=row=0, sum=0, and all outputs 0 (px_stb, p_x, p_y, wr_en, wr_addr, wr_data, mov_en, busy). Reset mid-frame abandons the frame; no further writes occur.
- States and transitions:
  - IDLE: frame_go=1 -> STROBE, busy=1.
  - STROBE: px_stb=1 for exactly one cycle, with p_x={col,15'b0} and p_y={row,15'b0}, zero-extended. Next state WAIT_ACK; timeout counter cleared.
  - WAIT_ACK: when &vld==0 (any ball busy) -> WAIT_DONE. If the counter reaches ACK_TO -> WAIT_DONE anyway (covers combinational or zero-latency responders).
  - WAIT_DONE: when &vld==1, latch sum = saturating unsigned sum of all out words, clamped at 32'h7FFF_FFFF -> WRITE. Stays here indefinitely otherwise.
  - WRITE: wr_en=1 one cycle, wr_addr=row*H_RES+col, wr_data=(sum>=THRESH).
    - If col==H_RES-1 and row==V_RES-1 -> MOVE.
    - Else if col==H_RES-1: col=0, row++ -> STROBE.
    - Else col++ -> STROBE.
  - MOVE: mov_en=1 one cycle, col=row=0 -> IDLE; busy drops the next cycle.
- p_x/p_y hold their value from STROBE until the next STROBE; they are not cleared between pixels.
- frame_go is ignored while busy. It is accepted again starting the cycle after MOVE.
- Negative out words (bit31=1) are treated as 0 before summation.
- Minimum per-pixel latency: 4 cycles (STROBE, WAIT_ACK, WAIT_DONE, WRITE) plus the divider duration.
- Exactly one wr_en per pixel per frame, in raster order. Exactly one mov_en per frame.

Test Plan:
- H_RES=4, V_RES=2, N_BALLS=1, model ball drops vld 1 cycle after px_stb and raises it 5 cycles later with out=32'h0001_0000. frame_go -> 8 writes to addr 0..7, all wr_data=1. Pixel (3,1) shows p_x=32'h0001_8000 and p_y=32'h0000_8000 at addr 7. One mov_en after addr 7; busy low afterwards.
- Threshold edges, N_BALLS=2: outs 32'h4000+32'h4000 -> sum 32'h8000, wr_data=1. Outs 32'h4000+32'h3FFF -> wr_data=0. Out with bit31 set plus 32'h8000 -> wr_data=1 (negative treated as 0).
- Saturation: outs 32'h7FFF_FFF0+32'h0000_0020 -> latched sum 32'h7FFF_FFFF, wr_data=1.
- Timeout: model ball never drops vld (out=32'h0) -> each pixel leaves WAIT_ACK after ACK_TO=8 cycles. All writes have wr_data=0; frame completes with mov_en.
- frame_go pulsed mid-frame -> ignored, exactly 8 writes and one mov_en. frame_go in the cycle after mov_en -> second frame starts at addr 0.
- rst asserted during WAIT_DONE of pixel 5 -> all outputs 0 immediately. After release, no writes occur until frame_go; the next frame starts at addr 0.

Source files
------------

// File: rtl/metaball_scan_if.sv
// Metaball evaluation bus: the scanner strobes a pixel coordinate to every
// ball and collects each ball's valid flag and Q16.15 field value.
interface metaball_scan_if #(
  parameter int N_BALLS = 2
);
  logic                     px_stb;
  logic [31:0]              p_x;
  logic [31:0]              p_y;
  logic [N_BALLS-1:0]       vld;
  logic [32*N_BALLS-1:0]    out;

  modport master (output px_stb, output p_x, output p_y, input vld, input out);
  modport slave  (input px_stb, input p_x, input p_y, output vld, output out);
endinterface

// File: rtl/metaball_scan.sv
// Pixel-side metaball driver: rasters the grid, strobes every ball with the
// pixel coordinate, sums and thresholds the returned field, writes one bit
// per pixel and pulses mov_en at the end of each frame.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   IDLE      | waiting for frame_go
//   STROBE    | px_stb high, p_x/p_y carry the current pixel
//   WAIT_ACK  | waiting for any ball to drop vld (or timeout)
//   WAIT_DONE | waiting for all vld high, then latch saturated sum
//   WRITE     | framebuffer write of the thresholded pixel
//   MOVE      | mov_en pulse, back to IDLE
module metaball_scan #(
  parameter int          H_RES   = 40,
  parameter int          V_RES   = 30,
  parameter int          N_BALLS = 2,
  parameter logic [31:0] THRESH  = 32'h0000_8000,
  parameter int          ACK_TO  = 8,
  parameter int          AW      = $clog2(H_RES*V_RES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_go,
  metaball_scan_if.master      mb,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic                 wr_data,
  output logic                 mov_en,
  output logic                 busy
);

  localparam int CW   = (H_RES  > 1) ? $clog2(H_RES)  : 1;
  localparam int RW   = (V_RES  > 1) ? $clog2(V_RES)  : 1;
  localparam int CNTW = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;
  localparam logic [CW-1:0]   COL_LAST = CW'(H_RES - 1);
  localparam logic [RW-1:0]   ROW_LAST = RW'(V_RES - 1);
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(ACK_TO - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_STROBE, S_WAIT_ACK, S_WAIT_DONE, S_WRITE, S_MOVE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [31:0]      sum_q, sum_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [31:0]      p_x_q, p_x_d;
  logic [31:0]      p_y_q, p_y_d;
  logic [39:0]      acc;
  logic [31:0]      word;
  logic [31:0]      sat_sum;

  // Saturating sum of all ball outputs; negative words contribute nothing.
  always_comb begin
    acc  = '0;
    word = '0;
    for (int k = 0; k < N_BALLS; k++) begin
      word = mb.out[32*k +: 32];
      if (!word[31]) acc = acc + {8'b0, word};
    end
    sat_sum = (acc > 40'h00_7FFF_FFFF) ? 32'h7FFF_FFFF : acc[31:0];
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      p_x_q   <= '0;
      p_y_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      p_x_q   <= p_x_d;
      p_y_q   <= p_y_d;
    end
  end

  // Next-state logic and decoded outputs.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    p_x_d   = p_x_q;
    p_y_d   = p_y_q;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = 1'b0;
    mov_en  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (frame_go) state_d = S_STROBE;
      end
      S_STROBE: begin
        cnt_d   = CNT_LOAD;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        // Timeout covers balls that answer without ever dropping vld.
        if (!(&mb.vld) || cnt_q == '0) state_d = S_WAIT_DONE;
        else                           cnt_d   = cnt_q - 1'b1;
      end
      S_WAIT_DONE: begin
        if (&mb.vld) begin
          sum_d   = sat_sum;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        wr_en   = 1'b1;
        wr_addr = AW'(row_q) * AW'(H_RES) + AW'(col_q);
        wr_data = (sum_q >= THRESH);
        if (col_q == COL_LAST) begin
          col_d = '0;
          if (row_q == ROW_LAST) begin
            state_d = S_MOVE;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = S_STROBE;
          end
        end else begin
          col_d   = col_q + 1'b1;
          state_d = S_STROBE;
        end
      end
      S_MOVE: begin
        mov_en  = 1'b1;
        col_d   = '0;
        row_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Coordinates are captured on entry to STROBE and held until the next one.
    if (state_d == S_STROBE) begin
      p_x_d = 32'(col_d) << 15;
      p_y_d = 32'(row_d) << 15;
    end
  end

  assign mb.px_stb = (state_q == S_STROBE);
  assign mb.p_x    = p_x_q;
  assign mb.p_y    = p_y_q;
  assign busy      = (state_q != S_IDLE);

endmodule
